// File: rtl/uart_pkg.sv
// Shared UART types and helpers: data width, TX feeder FSM states, baud divider.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {TXF_IDLE, TXF_LAUNCH, TXF_WAIT} txf_state_t;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host-write and UART-TX signal bundle for uart_tx_fifo_ctrl.
// slave = controller view, master = host/UART view.
interface uart_tx_fifo_ctrl_if #(parameter int DEPTH = 16);
  import uart_pkg::*;

  logic                     wr_en;
  logic [UART_DATA_W-1:0]   wr_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     busy;
  logic                     newd;
  logic [UART_DATA_W-1:0]   dintx;
  logic                     donetx;
  logic                     ovf;

  modport slave (
    input  wr_en, wr_data, donetx,
    output full, empty, level, busy, newd, dintx, ovf
  );

  modport master (
    output wr_en, wr_data, donetx,
    input  full, empty, level, busy, newd, dintx, ovf
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; a write at full is accepted when a
// pop happens in the same cycle (the freed slot is the one being written).
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// TX feeder: FIFO-buffered host bytes launched one at a time to the UART TX,
// newd stretched over a baud period. Optional sticky overflow: UART_TX_FIFO_OVF_EN.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD        = 9600,
  parameter int DEPTH       = 16,
  parameter int NEWD_CYCLES = calc_baud_div(CLK_FREQ, BAUD)
) (
  input logic               clk,
  input logic               rst,
  uart_tx_fifo_ctrl_if.slave bus
);
  localparam int CW = $clog2(NEWD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(NEWD_CYCLES - 1);

  txf_state_t             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   newd_q, newd_n;
  logic [UART_DATA_W-1:0] dintx_q, dintx_n, rd_data;
  logic                   donetx_q, done_rise, pop;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (bus.full),
    .empty   (bus.empty),
    .level   (bus.level)
  );

  // A long donetx must complete only one byte, hence the edge detect.
  assign done_rise = bus.donetx & ~donetx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TXF_IDLE;
      cnt      <= '0;
      newd_q   <= 1'b0;
      dintx_q  <= '0;
      donetx_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      newd_q   <= newd_n;
      dintx_q  <= dintx_n;
      donetx_q <= bus.donetx;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    newd_n  = newd_q;
    dintx_n = dintx_q;
    pop     = 1'b0;
    case (state)
      TXF_IDLE: begin
        if (!bus.empty) begin
          pop     = 1'b1;
          dintx_n = rd_data;
          newd_n  = 1'b1;
          cnt_n   = HOLD_LOAD;
          state_n = TXF_LAUNCH;
        end
      end
      TXF_LAUNCH: begin
        if (done_rise) begin
          newd_n  = 1'b0;
          state_n = TXF_IDLE;
        end else if (cnt == '0) begin
          newd_n  = 1'b0;
          state_n = TXF_WAIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      TXF_WAIT: begin
        if (done_rise) state_n = TXF_IDLE;
      end
      default: state_n = TXF_IDLE;
    endcase
  end

  assign bus.newd  = newd_q;
  assign bus.dintx = dintx_q;
  assign bus.busy  = (state != TXF_IDLE);

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 ovf_q <= 1'b0;
    else if (bus.wr_en && bus.full && !pop)  ovf_q <= 1'b1;
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl (DEPTH=16, 104-cycle newd hold).
module tb_uart_tx_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  uart_tx_fifo_ctrl_if #(.DEPTH(16)) bus();

  uart_tx_fifo_ctrl #(.CLK_FREQ(1000000), .BAUD(9600), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time expired, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_newd(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.newd === v) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic done_pulse();
    bus.donetx = 1'b1;
    tick();
    bus.donetx = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.level !== 5'd0) begin errs++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.newd !== 1'b0) begin errs++; $display("FAIL reset_newd got=%b exp=0", bus.newd); end
    checks++; if (bus.dintx !== 8'h00) begin errs++; $display("FAIL reset_dintx got=%h exp=00", bus.dintx); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_launch();
    wr(8'hA5);
    tick();
    checks++; if (bus.newd !== 1'b1 || bus.dintx !== 8'hA5) begin errs++; $display("FAIL midrst_launch newd=%b dintx=%h exp 1/a5", bus.newd, bus.dintx); end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.newd !== 1'b0) begin errs++; $display("FAIL midrst_newd got=%b exp=0", bus.newd); end
    checks++; if (bus.dintx !== 8'h00) begin errs++; $display("FAIL midrst_dintx got=%h exp=00", bus.dintx); end
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL midrst_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.newd !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL midrst_no_retry newd=%b busy=%b exp 0/0", bus.newd, bus.busy); end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    wr(8'h3C);
    wait_newd(1'b1, ok);
    checks++; if (!ok) begin errs++; $display("FAIL single_launch_timeout got=no newd exp=newd"); end
    checks++; if (bus.dintx !== 8'h3C) begin errs++; $display("FAIL single_dintx got=%h exp=3c", bus.dintx); end
    n = 0;
    while (bus.newd === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    checks++; if (n != 104) begin errs++; $display("FAIL single_newd_len got=%0d exp=104", n); end
    checks++; if (bus.busy !== 1'b1 || bus.dintx !== 8'h3C) begin errs++; $display("FAIL single_wait busy=%b dintx=%h exp 1/3c", bus.busy, bus.dintx); end
    bus.donetx = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_done_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.level !== 5'd0) begin errs++; $display("FAIL single_done_level got=%0d exp=0", bus.level); end
    bus.donetx = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] b;
    // Park the FSM in WAIT_DONE on a filler byte so the burst accumulates.
    wr(8'hF0);
    wait_newd(1'b1, ok);
    wait_newd(1'b0, ok);
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      wr(b);
    end
    checks++; if (bus.level !== 5'd5) begin errs++; $display("FAIL burst_peak got=%0d exp=5", bus.level); end
    bus.donetx = 1'b1;
    tick();
    bus.donetx = 1'b0;
    tick();
    checks++; if (bus.level !== 5'd4) begin errs++; $display("FAIL burst_after_pop got=%0d exp=4", bus.level); end
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      wait_newd(1'b1, ok);
      checks++; if (!ok || bus.dintx !== b) begin errs++; $display("FAIL burst_order got=%h exp=%h ok=%b", bus.dintx, b, ok); end
      wait_newd(1'b0, ok);
      done_pulse();
    end
    checks++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1) begin errs++; $display("FAIL burst_drained busy=%b empty=%b exp 0/1", bus.busy, bus.empty); end
  endtask

  task automatic test_full();
    bit ok;
    logic exp_ovf;
    logic [7:0] b;
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    wr(8'h90);
    wait_newd(1'b1, ok);
    wait_newd(1'b0, ok);
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      wr(b);
    end
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin errs++; $display("FAIL full_16 level=%0d full=%b exp 16/1", bus.level, bus.full); end
    checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL full_ovf_early got=%b exp=0", bus.ovf); end
    wr(8'h20);
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin errs++; $display("FAIL full_drop level=%0d full=%b exp 16/1", bus.level, bus.full); end
    checks++; if (bus.ovf !== exp_ovf) begin errs++; $display("FAIL full_ovf got=%b exp=%b", bus.ovf, exp_ovf); end
  endtask

  task automatic test_full_write_pop();
    bit ok;
    logic [7:0] exp;
    bus.donetx = 1'b1;
    tick();
    // FSM is back in IDLE; this edge both pops and writes.
    bus.donetx  = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.level !== 5'd16) begin errs++; $display("FAIL wrpop_level got=%0d exp=16", bus.level); end
    checks++; if (bus.newd !== 1'b1 || bus.dintx !== 8'h10) begin errs++; $display("FAIL wrpop_launch newd=%b dintx=%h exp 1/10", bus.newd, bus.dintx); end
    for (int k = 0; k < 17; k++) begin
      exp = (k < 16) ? 8'h10 + 8'(k) : 8'hEE;
      wait_newd(1'b1, ok);
      checks++; if (!ok || bus.dintx !== exp) begin errs++; $display("FAIL wrpop_order idx=%0d got=%h exp=%h ok=%b", k, bus.dintx, exp, ok); end
      wait_newd(1'b0, ok);
      done_pulse();
    end
    checks++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL wrpop_drained empty=%b busy=%b exp 1/0", bus.empty, bus.busy); end
  endtask

  task automatic test_long_done();
    bit ok;
    int rises;
    logic prev;
    wr(8'h55);
    wr(8'h66);
    wait_newd(1'b0, ok);
    checks++; if (!ok || bus.busy !== 1'b1 || bus.dintx !== 8'h55) begin errs++; $display("FAIL long_first busy=%b dintx=%h exp 1/55", bus.busy, bus.dintx); end
    bus.donetx = 1'b1;
    rises = 0;
    prev  = bus.newd;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.newd === 1'b1 && prev !== 1'b1) rises++;
      prev = bus.newd;
    end
    checks++; if (rises != 1) begin errs++; $display("FAIL long_launches got=%0d exp=1", rises); end
    checks++; if (bus.dintx !== 8'h66 || bus.busy !== 1'b1 || bus.level !== 5'd0) begin errs++; $display("FAIL long_state dintx=%h busy=%b level=%0d exp 66/1/0", bus.dintx, bus.busy, bus.level); end
    bus.donetx = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL long_fall_busy got=%b exp=1", bus.busy); end
    done_pulse();
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL long_end_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.donetx  = 1'b0;
    test_reset();
    test_reset_mid_launch();
    test_single();
    test_burst();
    test_full();
    test_full_write_pop();
    test_long_done();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
